// File: rtl/pru_pkg.sv
// Shared defaults, FSM state encoding and FIFO payload layout for the PRU buffer reader.
package pru_pkg;

  localparam int unsigned IMG_W_DEF  = 50;
  localparam int unsigned IMG_H_DEF  = 50;
  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned PIX_W      = 2;
  localparam int unsigned IDX_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 15-bit entry: pixel value, its coordinates and the end-of-frame marker
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } pix_t;

endpackage

// File: rtl/pru_skid_fifo.sv
// Two-entry FIFO holding tagged pixels; the head entry is presented directly and
// stays put until popped.
module pru_skid_fifo
  import pru_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  pix_t       din_i,
  input  logic       pop_i,
  output pix_t       head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  pix_t       e0_q;
  pix_t       e1_q;
  logic [1:0] cnt_q;

  // e0 is always the head; e1 only holds the second-oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_q <= din_i;
          end else begin
            e1_q <= din_i;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= din_i;
          end else begin
            e0_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/pru_buffer_reader.sv
// Streams one frame out of the image buffer as (pixel, row, col) beats with
// valid/ready flow control, bounded read-ahead and a done pulse per frame.
module pru_buffer_reader
  import pru_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] re_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic [IDX_W-1:0]  pix_row,
  output logic [IDX_W-1:0]  pix_col,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(IMG_H - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   re_addr_q;
  logic [ADDR_W-1:0]   nxt_addr_q;
  logic                issue_q;
  logic                pend_q;
  logic [IDX_W-1:0]    cap_row_q;
  logic [IDX_W-1:0]    cap_col_q;
  logic                busy_q;
  logic                done_q;

  pix_t                fifo_head;
  logic                fifo_valid;
  logic [1:0]          fifo_cnt;
  pix_t                cap_pix_c;
  logic                pop_c;
  logic                push_c;
  logic                issue_c;
  logic [2:0]          used_c;

  // issue_q: address just driven; pend_q: its data is on rd_data and not yet captured.
  // A pending read that cannot be captured stays valid because re_addr is held,
  // so the budget is two FIFO slots plus that one read on the bus.
  always_comb begin
    pop_c   = fifo_valid & pix_ready;
    push_c  = pend_q & ((fifo_cnt != 2'd2) | pop_c);
    used_c  = 3'(fifo_cnt) - 3'(pop_c) + 3'(pend_q) + 3'(issue_q);
    issue_c = (state_q == ST_FETCH) && (used_c < 3'd3);

    cap_pix_c      = '0;
    cap_pix_c.data = rd_data;
    cap_pix_c.row  = cap_row_q;
    cap_pix_c.col  = cap_col_q;
    cap_pix_c.last = (cap_row_q == LAST_ROW) && (cap_col_q == LAST_COL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      re_addr_q  <= '0;
      nxt_addr_q <= '0;
      issue_q    <= 1'b0;
      pend_q     <= 1'b0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      issue_q <= issue_c;
      pend_q  <= issue_q | (pend_q & ~push_c);

      if (issue_c) begin
        re_addr_q  <= nxt_addr_q;
        nxt_addr_q <= nxt_addr_q + ADDR_W'(1);
      end

      // Coordinates tag each pixel as it enters the FIFO
      if (push_c) begin
        if (cap_col_q == LAST_COL) begin
          cap_col_q <= '0;
          cap_row_q <= cap_row_q + IDX_W'(1);
        end else begin
          cap_col_q <= cap_col_q + IDX_W'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_FETCH;
            busy_q     <= 1'b1;
            nxt_addr_q <= '0;
            cap_row_q  <= '0;
            cap_col_q  <= '0;
          end
        end
        ST_FETCH: begin
          if (issue_c && (nxt_addr_q == LAST_ADDR)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_c && fifo_head.last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pru_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (cap_pix_c),
    .pop_i   (pop_c),
    .head_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign re_addr   = re_addr_q;
  assign pix_data  = fifo_head.data;
  assign pix_row   = fifo_head.row;
  assign pix_col   = fifo_head.col;
  assign pix_last  = fifo_head.last;
  assign pix_valid = fifo_valid;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pru_buffer_reader.sv
// Frame-level bench: image buffer model holds (addr mod 4); each table row runs one
// frame under a ready pattern and checks every pixel, timing, flow control and done.
module tb_pru_buffer_reader;

  localparam int unsigned W    = 50;
  localparam int unsigned H    = 50;
  localparam int unsigned AW   = 19;
  localparam int          NPIX = 2500;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] re_addr;
  logic [1:0]    rd_data;
  logic [1:0]    pix_data;
  logic [5:0]    pix_row;
  logic [5:0]    pix_col;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last;
  logic          busy;
  logic          done;

  logic [1:0]    mem [NPIX];

  int n_tests = 0;
  int n_fail  = 0;

  // mode: 0 ready always, 1 ready on even cycles, 2 twenty-cycle stall at pixel 49
  typedef struct {
    int mode;
    int busy_start;
    bit chain;
    int rst_pix;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  pru_buffer_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .re_addr   (re_addr),
    .rd_data   (rd_data),
    .pix_data  (pix_data),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer: address sampled on the edge, data valid the next cycle
  always @(posedge clk) begin
    if (int'(re_addr) < NPIX) rd_data <= mem[int'(re_addr)];
    else                      rd_data <= 2'd0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_re_addr"},   int'(re_addr),   0);
    check({pfx, "_pix_valid"}, int'(pix_valid), 0);
    check({pfx, "_pix_data"},  int'(pix_data),  0);
    check({pfx, "_pix_row"},   int'(pix_row),   0);
    check({pfx, "_pix_col"},   int'(pix_col),   0);
    check({pfx, "_pix_last"},  int'(pix_last),  0);
    check({pfx, "_busy"},      int'(busy),      0);
    check({pfx, "_done"},      int'(done),      0);
  endtask

  task automatic run_frame(input vec_t v, input bit prestarted, output bit chained_o);
    int   k, first_valid, done_cyc, stall_left;
    int   addr_err, stab_err, busy_err, quiet_err;
    bit   rdy, prev_hold, stalled_once, got_done;
    logic [1:0] pd;
    logic [5:0] pr, pc;
    logic       pl;

    chained_o = 1'b0;
    if (!prestarted) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    k = 0; first_valid = -1; done_cyc = -1; stall_left = 0;
    addr_err = 0; stab_err = 0; busy_err = 0;
    prev_hold = 1'b0; stalled_once = 1'b0; got_done = 1'b0;
    pd = '0; pr = '0; pc = '0; pl = 1'b0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc == 0) begin
        check("busy_after_start", int'(busy), 1);
        check("done_low_at_start", int'(done), 0);
      end
      if (cyc == 1) check("first_read_addr", int'(re_addr), 0);

      if (v.rst_pix >= 0 && k == v.rst_pix && pix_valid) begin
        rst = 1'b1;
        step();
        check_idle("abort");
        rst = 1'b0;
        quiet_err = 0;
        for (int i = 0; i < 10; i++) begin
          step();
          if (pix_valid || done || busy) quiet_err++;
        end
        check("abort_quiet", quiet_err, 0);
        return;
      end

      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end

      if (cyc >= 1 && int'(re_addr) > k + 2) addr_err++;
      if (!busy) busy_err++;
      if (prev_hold && (!pix_valid || pix_data != pd || pix_row != pr ||
                        pix_col != pc || pix_last != pl)) stab_err++;
      if (pix_valid && first_valid < 0) first_valid = cyc;

      case (v.mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: begin
          if (pix_valid && k == 49 && !stalled_once) begin
            stall_left   = 20;
            stalled_once = 1'b1;
          end
          if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
            if (stall_left == 0) begin
              check("stall_hold_valid", int'(pix_valid), 1);
              check("stall_hold_row",   int'(pix_row),   0);
              check("stall_hold_col",   int'(pix_col),   49);
            end
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      pix_ready = rdy;
      start     = (cyc == v.busy_start);

      if (pix_valid && rdy) begin
        check("pix_data", int'(pix_data), k % 4);
        check("pix_row",  int'(pix_row),  k / int'(W));
        check("pix_col",  int'(pix_col),  k % int'(W));
        check("pix_last", int'(pix_last), (k == NPIX - 1) ? 1 : 0);
        k++;
      end

      prev_hold = pix_valid && !rdy;
      pd = pix_data; pr = pix_row; pc = pix_col; pl = pix_last;
      step();
    end

    start = 1'b0;
    check("done_seen",         int'(got_done), 1);
    check("done_cycle",        done_cyc,       v.exp_done);
    check("pixel_count",       k,              NPIX);
    check("first_valid_cycle", first_valid,    3);
    check("busy_low_at_done",  int'(busy),     0);
    check("valid_low_at_done", int'(pix_valid), 0);
    check("readahead_bound",   addr_err,       0);
    check("stall_stability",   stab_err,       0);
    check("busy_during_frame", busy_err,       0);

    if (v.chain) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chained_o = 1'b1;
    end else begin
      step();
      check("done_single_cycle", int'(done), 0);
    end
  endtask

  initial begin
    bit chained, chained_nxt;

    vecs[0] = '{mode: 0, busy_start: -1,  chain: 1'b0, rst_pix: -1,   exp_done: 2503};
    vecs[1] = '{mode: 1, busy_start: -1,  chain: 1'b0, rst_pix: -1,   exp_done: 5003};
    vecs[2] = '{mode: 2, busy_start: -1,  chain: 1'b0, rst_pix: -1,   exp_done: 2523};
    vecs[3] = '{mode: 0, busy_start: 100, chain: 1'b1, rst_pix: -1,   exp_done: 2503};
    vecs[4] = '{mode: 0, busy_start: -1,  chain: 1'b0, rst_pix: -1,   exp_done: 2503};
    vecs[5] = '{mode: 0, busy_start: -1,  chain: 1'b0, rst_pix: 1000, exp_done: -1};
    vecs[6] = '{mode: 0, busy_start: -1,  chain: 1'b0, rst_pix: -1,   exp_done: 2503};

    for (int i = 0; i < NPIX; i++) mem[i] = 2'(i % 4);

    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check("idle_no_busy", int'(busy), 0);

    chained = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], chained, chained_nxt);
      chained = chained_nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
